// File: rtl/mul_seq_shift_add.sv
// rtl/mul_seq_shift_add.sv - sequential 32x32->64 shift-and-add multiplier driving an external ripple adder
// One partial-product accumulation per commit; each adder evaluation is given ADD_WAIT clocks to settle.
module mul_seq_shift_add #(
  parameter int WIDTH    = 32,
  parameter int ADD_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_x,
  output logic [WIDTH-1:0]     add_y,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_s,
  input  logic                 add_cout
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] WCNT_LAST = 4'(ADD_WAIT - 1);
  localparam logic [5:0] STEP_LAST = 6'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [5:0]           step_q, step_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [2*WIDTH-1:0]   commit_val;

  // 33-bit adder result shifted right by one, with the retired multiplier bit dropping out of lo
  assign commit_val = {add_cout, add_s, lo_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    acc_hi_d  = acc_hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    step_d    = step_q;
    wcnt_d    = wcnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_hi_d = '0;
          lo_d     = a;
          mcand_d  = b;
          step_d   = '0;
          wcnt_d   = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (wcnt_q != WCNT_LAST) begin
          wcnt_d = wcnt_q + 4'd1;
        end else begin
          acc_hi_d = commit_val[2*WIDTH-1:WIDTH];
          lo_d     = commit_val[WIDTH-1:0];
          wcnt_d   = '0;
          step_d   = step_q + 6'd1;
          if (step_q == STEP_LAST) begin
            product_d = commit_val;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_hi_q  <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      step_q    <= '0;
      wcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_hi_q  <= acc_hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      step_q    <= step_d;
      wcnt_q    <= wcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  // Adder operands come from registers only, so they stay stable across a wait window
  assign add_x   = acc_hi_q;
  assign add_y   = lo_q[0] ? mcand_q : '0;
  assign add_cin = 1'b0;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_mul_seq_shift_add.sv
// tb/tb_mul_seq_shift_add.sv - scoreboard bench for mul_seq_shift_add with behavioural ripple adders
module tb_mul_seq_shift_add;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start1, start3;
  logic [31:0] a1, b1, a3, b3;
  logic        busy1, done1, add_cin1, add_cout1;
  logic        busy3, done3, add_cin3, add_cout3;
  logic [63:0] product1, product3;
  logic [31:0] add_x1, add_y1, add_s1, add_x3, add_y3, add_s3;

  assign {add_cout1, add_s1} = {1'b0, add_x1} + {1'b0, add_y1} + {32'd0, add_cin1};
  assign {add_cout3, add_s3} = {1'b0, add_x3} + {1'b0, add_y3} + {32'd0, add_cin3};

  mul_seq_shift_add #(.WIDTH(32), .ADD_WAIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .product(product1),
    .add_x(add_x1), .add_y(add_y1), .add_cin(add_cin1),
    .add_s(add_s1), .add_cout(add_cout1)
  );

  mul_seq_shift_add #(.WIDTH(32), .ADD_WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .product(product3),
    .add_x(add_x3), .add_y(add_y3), .add_cin(add_cin3),
    .add_s(add_s3), .add_cout(add_cout3)
  );

  int total = 0;
  int bad = 0;
  logic [63:0] q1[$];
  logic [63:0] q3[$];
  logic cout_seen = 1'b0;
  logic ymon = 1'b0;
  int   y_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) check("unexpected_done1", {63'd0, done1}, 64'd0);
      else check("product1", product1, q1.pop_front());
    end
    if (done3) begin
      if (q3.size() == 0) check("unexpected_done3", {63'd0, done3}, 64'd0);
      else check("product3", product3, q3.pop_front());
    end
    if (busy1 && add_cout1) cout_seen = 1'b1;
    if (ymon && busy1 && add_y1 != 32'd0) y_bad++;
  end

  task automatic start_mul1(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    a1 = a; b1 = b; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  // Returns the number of edges after the start edge until done is seen, and busy cycles counted
  task automatic wait_done1(output int lat, output int busy_cnt);
    lat = -1; busy_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy1) busy_cnt++;
      if (done1) begin lat = i; break; end
    end
    if (lat < 0) check("timeout1", 64'd1, 64'd0);
  endtask

  int lat, bc, stable_bad;
  logic [63:0] prev_xy;

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    a1 = '0; b1 = '0; a3 = '0; b3 = '0;
    #12;
    check("rst_busy",    {63'd0, busy1},    64'd0);
    check("rst_done",    {63'd0, done1},    64'd0);
    check("rst_product", product1,          64'd0);
    check("rst_add_x",   {32'd0, add_x1},   64'd0);
    check("rst_add_y",   {32'd0, add_y1},   64'd0);
    check("rst_add_cin", {63'd0, add_cin1}, 64'd0);
    @(negedge clk); rst = 1'b0;

    q1.push_back(64'h0000_0000_0000_000F);
    start_mul1(32'd3, 32'd5);
    wait_done1(lat, bc);
    check("lat_3x5", 64'(lat), 64'd32);
    check("busy_cycles_3x5", 64'(bc), 64'd32);

    cout_seen = 1'b0;
    q1.push_back(64'hFFFF_FFFE_0000_0001);
    start_mul1(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done1(lat, bc);
    check("cout_seen", {63'd0, cout_seen}, 64'd1);

    y_bad = 0; ymon = 1'b1;
    q1.push_back(64'd0);
    start_mul1(32'd0, 32'h1234_5678);
    wait_done1(lat, bc);
    ymon = 1'b0;
    check("add_y_zero", 64'(y_bad), 64'd0);
    q1.push_back(64'd0);
    start_mul1(32'h1234_5678, 32'd0);
    wait_done1(lat, bc);

    q3.push_back(64'd63);
    @(posedge clk); #1;
    a3 = 32'd7; b3 = 32'd9; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    lat = -1; stable_bad = 0; prev_xy = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (n > 0 && (n % 3) != 0 && {add_x3, add_y3} != prev_xy) stable_bad++;
      prev_xy = {add_x3, add_y3};
      if (done3) begin lat = n; break; end
    end
    check("lat_aw3", 64'(lat), 64'd96);
    check("add_stable_aw3", 64'(stable_bad), 64'd0);

    q1.push_back(64'd6);
    start_mul1(32'd2, 32'd3);
    repeat (9) @(posedge clk);
    #1; a1 = 32'd1; b1 = 32'd1; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    wait_done1(lat, bc);

    q1.push_back(64'd20);
    q1.push_back(64'd42);
    @(posedge clk); #1;
    a1 = 32'd4; b1 = 32'd5; start1 = 1'b1;
    @(posedge clk); #1;
    a1 = 32'd6; b1 = 32'd7;
    wait_done1(lat, bc);
    @(negedge clk);
    check("b2b_busy", {63'd0, busy1}, 64'd1);
    check("b2b_done", {63'd0, done1}, 64'd0);
    start1 = 1'b0;
    wait_done1(lat, bc);
    check("b2b_lat", 64'(lat), 64'd31);

    start_mul1(32'd2, 32'd3);
    repeat (14) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy",    {63'd0, busy1}, 64'd0);
    check("abort_done",    {63'd0, done1}, 64'd0);
    check("abort_product", product1,       64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_product_hold", product1, 64'd0);
    q1.push_back(64'd143);
    start_mul1(32'd11, 32'd13);
    wait_done1(lat, bc);

    repeat (2) @(negedge clk);
    check("queues_empty", 64'(q1.size() + q3.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_seq_shift_add.md
Name: mul_seq_shift_add

Overview:
- Unsigned 32x32 -> 64-bit sequential shift-and-add multiplier controller for the ALU datapath.
- Sits directly around the 32-bit ripple adder:
  - drives the adder's x, y and cin inputs;
  - consumes its s and cout outputs;
  - performs one partial-product accumulation per step.
- Gives the ALU a multiply result without a dedicated array multiplier.

Parameters:
- WIDTH, 32, operand width. Must equal the adder width. Only 32 is supported.
- ADD_WAIT, 1, clocks allowed for each adder evaluation, to cover ripple settling time. Legal range is 1..15.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, reset: asynchronous, active-high.
- start, input, 1, request a multiply. Sampled only when busy=0.
- a, input, 32, multiplier. Captured on the start edge.
- b, input, 32, multiplicand. Captured on the start edge.
- busy, output, 1, high while a multiply is in progress.
- done, output, 1, single-cycle pulse; product is valid from this cycle.
- product, output, 64, result. Held until the next completion or reset.
- add_x, output, 32, to adder x: the current accumulator high word.
- add_y, output, 32, to adder y: the multiplicand if the multiplier LSB is 1, else 0.
- add_cin, output, 1, to adder cin: constant 0.
- add_s, input, 32, from adder s.
- add_cout, input, 1, from adder cout.

Behaviour:
- Internal registers:
  - acc_hi[31:0], accumulator high word;
  - lo[31:0], multiplier / low product;
  - mcand[31:0];
  - step[5:0];
  - wcnt[3:0];
  - state in {IDLE, RUN}.
- Reset (async, rst=1):
  - state=IDLE;
  - all registers 0, so busy=0, done=0, product=0, add_x=0, add_y=0, add_cin=0.
  - Reset asserted mid-operation aborts the multiply immediately. No done is produced and product reads 0.
- IDLE, start=1 at a rising edge:
  - acc_hi<=0, lo<=a, mcand<=b, step<=0, wcnt<=0;
  - state<=RUN, busy<=1.
- IDLE, start=0: hold all state.
- RUN, each edge:
  - If wcnt != ADD_WAIT-1: wcnt<=wcnt+1. acc_hi and lo are held, so the adder inputs stay stable.
  - Else (commit): {acc_hi, lo} <= {add_cout, add_s, lo[31:1]} (33-bit sum shifted right by one); wcnt<=0; step<=step+1.
- Final commit (step==31 at the commit edge), same edge:
  - product <= the shifted value;
  - done<=1, busy<=0, state<=IDLE.
- Adder drive:
  - add_x=acc_hi; add_y = lo[0] ? mcand : 0; add_cin=0.
  - All are combinational from registers only, with no path from start, a or b.
- Latency: start edge at E0. Commits at E0 + k*ADD_WAIT for k=1..32. done is high for exactly the one cycle following edge E0+32*ADD_WAIT.
- done is deasserted on the next edge unconditionally.
- start during busy=1 is ignored; a and b are not recaptured.
- start high in the done cycle (busy=0) is accepted. The back-to-back multiply begins, and done drops on that same edge.
- product changes only at a final commit edge or on reset.
- Arithmetic: the 33-bit adder result never overflows because the accumulator high word is at most 2^32-1 before each add. Final product is exactly a*b modulo 2^64, i.e. exact.
- Timing: the clock period times ADD_WAIT must exceed the adder's worst-case ripple delay, about 64 gate delays.

Test Plan:
- a=3, b=5, ADD_WAIT=1, start pulse -> busy for 32 cycles; done 1 cycle; product=64'h0000_0000_0000_000F.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF -> product=64'hFFFFFFFE_00000001. add_cout=1 observed on at least one commit.
- a=0, b=32'h1234_5678 -> add_y=0 on every step; product=0. Swapping operands (a=32'h1234_5678, b=0) also gives 0.
- ADD_WAIT=3, a=7, b=9 -> done exactly 96 cycles after the start edge; product=63. Adder inputs are stable across each 3-cycle window.
- start re-pulsed with a=1, b=1 at cycle 10 of a=2, b=3 -> ignored; product=6. start held high through the done cycle -> a second multiply begins with no idle gap.
- rst asserted asynchronously at cycle 15 of a multiply -> busy=0, done=0, product=0 immediately, with no done later. A new start then gives the correct result.
